// File: rtl/text_line_ctrl.sv
// Shares one multiple_text line between two character writers (A, B), committing at frame start.
// Optional blinking of the committed line is enabled with `define TEXT_LINE_CTRL_BLINK_EN.
module text_line_ctrl #(
  parameter int MAX_LETTERS  = 16,
  parameter int CHAR_BITS    = 6,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [10:0]                      hcount,
  input  logic [9:0]                       vcount,
  input  logic                             a_valid,
  input  logic [CHAR_BITS-1:0]             a_char,
  input  logic                             a_last,
  output logic                             a_ready,
  input  logic                             b_valid,
  input  logic [CHAR_BITS-1:0]             b_char,
  input  logic                             b_last,
  output logic                             b_ready,
  input  logic                             blink,
  output logic [MAX_LETTERS*CHAR_BITS-1:0] text,
  output logic                             busy,
  output logic                             owner,
  output logic                             commit,
  output logic                             overflow
);
  localparam int PTR_W  = $clog2(MAX_LETTERS + 1);
  localparam int IDX_W  = $clog2(MAX_LETTERS);
  localparam int TEXT_W = MAX_LETTERS * CHAR_BITS;

  typedef enum logic [1:0] {IDLE, WRITE, PENDING} state_t;

  state_t               state;
  state_t               state_next;
  logic [CHAR_BITS-1:0] shadow [MAX_LETTERS];
  logic [TEXT_W-1:0]    shadow_flat;
  logic [TEXT_W-1:0]    committed;
  logic [PTR_W-1:0]     wr_ptr;
  logic                 rr;
  logic                 frame_start;
  logic                 grant;
  logic                 grant_b;
  logic                 accept;
  logic                 in_valid;
  logic                 in_last;
  logic [CHAR_BITS-1:0] in_char;

  assign frame_start = (hcount == '0) && (vcount == '0);
  assign busy        = (state != IDLE);
  assign a_ready     = (state == WRITE) && !owner;
  assign b_ready     = (state == WRITE) && owner;

  assign in_valid = owner ? b_valid : a_valid;
  assign in_char  = owner ? b_char  : a_char;
  assign in_last  = owner ? b_last  : a_last;
  assign accept   = (state == WRITE) && in_valid;
  assign grant    = (state == IDLE) && (a_valid || b_valid);
  // rr breaks ties only; a lone requester always wins.
  assign grant_b  = (a_valid && b_valid) ? rr : b_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (a_valid || b_valid)    state_next = WRITE;
      WRITE:   if (accept && in_last)     state_next = PENDING;
      PENDING: if (frame_start)           state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
  end

  always_comb begin
    shadow_flat = '0;
    for (int i = 0; i < MAX_LETTERS; i++) shadow_flat[i*CHAR_BITS +: CHAR_BITS] = shadow[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= 1'b0;
      rr        <= 1'b0;
      wr_ptr    <= '0;
      overflow  <= 1'b0;
      committed <= '0;
      commit    <= 1'b0;
      for (int i = 0; i < MAX_LETTERS; i++) shadow[i] <= '0;
    end else begin
      commit <= 1'b0;
      if (grant) begin
        owner    <= grant_b;
        wr_ptr   <= '0;
        overflow <= 1'b0;
        for (int i = 0; i < MAX_LETTERS; i++) shadow[i] <= '0;
      end else if (accept) begin
        // Characters beyond the line width are dropped but flagged.
        if (wr_ptr < PTR_W'(MAX_LETTERS)) begin
          shadow[wr_ptr[IDX_W-1:0]] <= in_char;
          wr_ptr                    <= wr_ptr + PTR_W'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
      if ((state == PENDING) && frame_start) begin
        committed <= shadow_flat;
        commit    <= 1'b1;
        rr        <= ~owner;
      end
    end
  end

`ifdef TEXT_LINE_CTRL_BLINK_EN
  localparam int CNT_W = $clog2(BLINK_FRAMES + 1);

  logic [CNT_W-1:0] frame_cnt;
  logic             phase;

  // Phase is held at 0 whenever blink is low, so gating on phase alone keeps text registered.
  always_ff @(posedge clk) begin
    if (reset || !blink) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  assign text = phase ? '0 : committed;
`else
  localparam int blink_frames_unused = BLINK_FRAMES;
  logic blink_unused;

  assign blink_unused = blink;
  assign text         = committed;
`endif

endmodule

// File: tb/tb_text_line_ctrl.sv
// Self-checking bench for text_line_ctrl: message-level model compared every cycle plus literal checks.
// Blink expectations follow `define TEXT_LINE_CTRL_BLINK_EN with BLINK_FRAMES = 2.
module tb_text_line_ctrl;
  localparam int BF     = 2;
  localparam int M_IDLE = 0;
  localparam int M_COLL = 1;
  localparam int M_WAIT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hcount = 11'd5;
  logic [9:0]  vcount = 10'd7;
  logic        a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0, blink = 1'b0;
  logic [5:0]  a_char = '0, b_char = '0;
  logic        a_ready, b_ready, busy, owner, commit, overflow;
  logic [95:0] text;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  text_line_ctrl #(.MAX_LETTERS(16), .CHAR_BITS(6), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .a_valid(a_valid), .a_char(a_char), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_char(b_char), .b_last(b_last), .b_ready(b_ready),
    .blink(blink), .text(text), .busy(busy), .owner(owner), .commit(commit),
    .overflow(overflow)
  );

  // Message-level model: a queue of received codes and the last committed line.
  int m_mode = M_IDLE;
  bit m_owner, m_rr, m_commit, m_ovf, m_live, m_phase;
  int m_frames;
  int m_text [16];
  int m_msg [$];

  function automatic logic [95:0] model_text();
    logic [95:0] t = '0;
    for (int i = 0; i < 16; i++) t[i*6 +: 6] = 6'(m_text[i]);
`ifdef TEXT_LINE_CTRL_BLINK_EN
    if (m_phase) t = '0;
`endif
    return t;
  endfunction

  task automatic check_output(input string name, input logic [95:0] actual, input logic [95:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  always @(posedge clk) begin
    bit fs, v, l;
    int c;
    fs = (hcount == 0) && (vcount == 0);
    m_commit = 1'b0;
    if (reset) begin
      m_mode = M_IDLE; m_owner = 0; m_rr = 0; m_ovf = 0; m_live = 1;
      m_msg.delete();
      foreach (m_text[i]) m_text[i] = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (a_valid || b_valid) begin
          m_owner = (a_valid && b_valid) ? m_rr : b_valid;
          m_msg.delete();
          m_ovf  = 0;
          m_mode = M_COLL;
        end
        M_COLL: begin
          v = m_owner ? b_valid : a_valid;
          c = m_owner ? int'(b_char) : int'(a_char);
          l = m_owner ? b_last : a_last;
          if (v) begin
            if (m_msg.size() < 16) m_msg.push_back(c);
            else m_ovf = 1;
            if (l) m_mode = M_WAIT;
          end
        end
        default: if (fs) begin
          for (int i = 0; i < 16; i++) m_text[i] = (i < m_msg.size()) ? m_msg[i] : 0;
          m_commit = 1;
          m_rr     = !m_owner;
          m_mode   = M_IDLE;
        end
      endcase
    end
`ifdef TEXT_LINE_CTRL_BLINK_EN
    if (reset || !blink) begin
      m_frames = 0;
      m_phase  = 0;
    end else if (fs) begin
      m_frames++;
      if (m_frames == BF) begin
        m_frames = 0;
        m_phase  = !m_phase;
      end
    end
`endif
  end

  always @(negedge clk) begin
    if (m_live) begin
      check_output("a_ready", a_ready, (m_mode == M_COLL) && !m_owner);
      check_output("b_ready", b_ready, (m_mode == M_COLL) && m_owner);
      check_output("busy", busy, m_mode != M_IDLE);
      if (m_mode != M_IDLE) check_output("owner", owner, m_owner);
      check_output("commit", commit, m_commit);
      check_output("overflow", overflow, m_ovf);
      check_output("text", text, model_text());
    end
  end

  task automatic set_writer(input bit who, input bit v, input int c, input bit l);
    if (!who) begin a_valid = v; a_char = 6'(c); a_last = l; end
    else      begin b_valid = v; b_char = 6'(c); b_last = l; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      a_valid = 0; b_valid = 0; a_last = 0; b_last = 0;
      hcount = 11'd5; vcount = 10'd7;
    end
  endtask

  task automatic frame_pulse();
    @(negedge clk); hcount = 11'd0; vcount = 10'd0;
    @(negedge clk); hcount = 11'd5; vcount = 10'd7;
  endtask

  // Streams len codes starting at first; wait0 counts cycles the first character waited for ready.
  task automatic apply_stimulus(input bit who, input int len, input int first, input bit with_last,
                                output int wait0);
    int tries;
    wait0 = 0;
    for (int i = 0; i < len; i++) begin
      tries = 0;
      forever begin
        @(negedge clk);
        set_writer(who, 1, ((first + i - 1) % 62) + 1, with_last && (i == len - 1));
        if (who ? b_ready : a_ready) break;
        tries++;
        if (i == 0) wait0++;
        if (tries > 100) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL ready_timeout: writer %0d got no ready, expected ready within 100 cycles", who);
          set_writer(who, 0, 0, 0);
          return;
        end
      end
    end
    @(negedge clk);
    set_writer(who, 0, 0, 0);
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    reset = 0;
    check_output("reset_text", text, 96'h0);
    check_output("reset_busy", busy, 1'b0);

    $display("[TB] HI from writer A");
    apply_stimulus(0, 2, 8, 1, w);
    check_output("hi_ready_latency", 96'(w), 96'd1);
    idle(3);
    check_output("hi_no_early_commit", text, 96'h0);
    frame_pulse();
    check_output("hi_commit", commit, 1'b1);
    check_output("hi_text", text, 96'h248);

    $display("[TB] simultaneous requests, round robin");
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    @(negedge clk); set_writer(0, 1, 1, 1); set_writer(1, 1, 2, 1);
    @(negedge clk);
    check_output("rr_first_owner", owner, 1'b0);
    frame_pulse();
    check_output("rr_first_text", text, 96'd1);
    @(negedge clk);
    check_output("rr_second_owner", owner, 1'b1);
    check_output("rr_second_busy", busy, 1'b1);
    idle(1);
    frame_pulse();
    check_output("rr_second_text", text, 96'd2);

    $display("[TB] overflow from writer B");
    apply_stimulus(1, 18, 10, 1, w);
    check_output("ovf_set", overflow, 1'b1);
    frame_pulse();
    check_output("ovf_slot0", 96'(text[5:0]), 96'd10);
    check_output("ovf_slot15", 96'(text[95:90]), 96'd25);
    apply_stimulus(0, 1, 40, 1, w);
    check_output("ovf_cleared", overflow, 1'b0);
    frame_pulse();
    check_output("single_char_text", text, 96'd40);

    $display("[TB] stalled writer and mid-frame last");
    apply_stimulus(0, 2, 3, 0, w);
    idle(3);
    apply_stimulus(0, 1, 5, 1, w);
    @(negedge clk); hcount = 11'd0; vcount = 10'd3;
    @(negedge clk); hcount = 11'd5; vcount = 10'd0;
    @(negedge clk); hcount = 11'd5; vcount = 10'd7;
    check_output("midframe_no_commit", commit, 1'b0);
    check_output("midframe_text_held", text, 96'd40);
    frame_pulse();
    check_output("midframe_text", text, 96'h5103);

    $display("[TB] reset during WRITE");
    apply_stimulus(0, 5, 20, 0, w);
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_text", text, 96'h0);
    check_output("rst_a_ready", a_ready, 1'b0);
    apply_stimulus(0, 2, 30, 1, w);
    frame_pulse();
    check_output("rst_fresh_text", text, 96'h7DE);

    $display("[TB] blink");
    @(negedge clk); blink = 1;
    frame_pulse();
    frame_pulse();
`ifdef TEXT_LINE_CTRL_BLINK_EN
    check_output("blink_off_phase", text, 96'h0);
`else
    check_output("blink_ignored", text, 96'h7DE);
`endif
    frame_pulse();
    frame_pulse();
    check_output("blink_on_phase", text, 96'h7DE);
    frame_pulse();
    frame_pulse();
    @(negedge clk); blink = 0;
    @(negedge clk);
    check_output("blink_released", text, 96'h7DE);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/text_line_ctrl.md
# text_line_ctrl

Controller that owns one `multiple_text` line renderer and shares it between two message writers (A, B). Each writer streams 6-bit character codes through a valid/ready handshake into a shadow buffer. Writers are served round-robin. A completed message is committed to the renderer's 96-bit `text` word only at frame start, so a line never changes mid-frame. Sits between game/status logic and the text overlay in the pixel pipeline.

## Interface
- `MAX_LETTERS`, 16, character slots per line.
- `CHAR_BITS`, 6, bits per character code. Codes: 0 = blank, 1–26 = A–Z, 27–52 = a–z, 53–62 = 0–9.
- `BLINK_FRAMES`, 30, frames per blink half-period. Used only with `TEXT_LINE_CTRL_BLINK_EN`.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: synchronous, active-high.
- `hcount` in 11: current pixel column.
- `vcount` in 10: current pixel row.
- `a_valid` in 1: writer A presents a character.
- `a_char` in 6: writer A character code.
- `a_last` in 1: the current A character is the final one of its message.
- `a_ready` out 1: A character accepted this cycle when `a_valid` is also high.
- `b_valid`, `b_char`, `b_last`, `b_ready`: same as A, for writer B.
- `blink` in 1: requests blinking of the committed line.
- `text` out 96: packed line; slot i is at `[i*6 +: 6]`, first letter in the lowest bits. Drives `multiple_text.text`.
- `busy` out 1: state ≠ IDLE.
- `owner` out 1: 0 = A, 1 = B. Valid while `busy`.
- `commit` out 1: one-cycle pulse on the cycle `text` updates.
- `overflow` out 1: sticky; the current or last message exceeded `MAX_LETTERS`.

## Operation
- `frame_start` = (`hcount` == 0 && `vcount` == 0), decoded combinationally.
- **IDLE:**
  - If any valid input is high, grant a writer. A has priority when both are high and `rr` = 0; B has priority when `rr` = 1.
  - On grant: set `owner`, clear the shadow buffer to all zeros, set `wr_ptr` = 0, clear `overflow`, go to WRITE.
- **WRITE:**
  - Owner's ready = 1; the other ready = 0.
  - Each accepted character (valid && ready) with `wr_ptr` < `MAX_LETTERS`:
    - Write to `shadow[wr_ptr]`.
    - Increment `wr_ptr`, saturating at `MAX_LETTERS`.
  - Accepted characters with `wr_ptr` == `MAX_LETTERS` are discarded and set `overflow`.
  - Code 0 is stored as a blank.
  - Accepted with `last` = 1 → go to PENDING.
- **PENDING:**
  - Both readies are 0.
  - On `frame_start`: `text` ← shadow, `commit` = 1, `rr` ← ~`owner`, go to IDLE.
- `text` holds its last committed value between commits. Unwritten slots are 0, so they render nothing.
- **Boundaries:**
  - Valid deasserted mid-message: WRITE waits indefinitely.
  - Single-character message (first character has `last`): legal.
  - `frame_start` in the same cycle as a new valid while in PENDING: commit occurs; the grant is evaluated in IDLE on the following cycle.
  - The non-owner's valid is ignored until IDLE.
- **Reset** (any state, including mid-message):
  - State IDLE, `text` = 0, shadow = 0, `wr_ptr` = 0, `rr` = 0.
  - `a_ready` = `b_ready` = 0, `busy` = 0, `owner` = 0, `commit` = 0, `overflow` = 0.
  - An in-flight message is lost.

## Timing
- State, `text`, `commit`, `overflow`, `owner` and `rr` are registered.
- Readies are combinational from registered state/owner only. They never depend on valid.
- Valid seen in IDLE at cycle N → ready high at N+1. First character accepted at N+1 at the earliest.
- Streaming: one character per cycle while valid is held.
- `last` accepted at cycle M → PENDING from M+1.
- Commit on the first `frame_start` cycle at or after M+1. `text` and `commit` are visible the cycle after that edge.
- Minimum message-to-next-grant spacing: the PENDING wait plus one IDLE cycle.

## Configuration
- `TEXT_LINE_CTRL_BLINK_EN` defined:
  - A frame counter advances on each `frame_start` and a phase bit toggles every `BLINK_FRAMES` frames.
  - When `blink` = 1 and phase = 1, `text` outputs 0; the committed value is retained internally.
  - `blink` = 0 forces phase to 0 and clears the counter.
- Not defined:
  - `blink` is ignored and `text` is always the committed value.
  - No counter or phase logic is synthesized.

## Test plan
- Reset, then A sends "HI" (8, 9, `last` on 9) → `a_ready` high one cycle after `a_valid`. At the next `frame_start`, `text[11:0]` = {6'd9, 6'd8}, upper bits 0, `commit` pulses one cycle.
- A and B valid together from reset → A granted first. After A's commit, B is granted even though A is still valid (round-robin).
- 18-character message from B → first 16 characters stored, last 2 discarded, `overflow` = 1 after the 17th accept. `overflow` clears on the next grant.
- `last` accepted mid-frame → `text` is unchanged until `hcount` = `vcount` = 0. No `commit` before then.
- `reset` asserted during WRITE after 5 characters → all outputs at reset values next cycle. A fresh message then commits with no residue.
- With `TEXT_LINE_CTRL_BLINK_EN`, `BLINK_FRAMES` = 2, `blink` = 1 → `text` alternates committed/0 every 2 frames. `blink` = 0 → steady committed value.
